fifo_s1_sf: RTL and testbench
=============================

// Module: fifo_s1_sf
// PURPOSE
//  Single-clock synchronous FIFO with static (count-derived, registered) status flags.
//  Used as the per-port output buffer in the NoC router.
//  Producer pushes flits; the credit logic pops one word per credit.
//  Push/pop requests are active-low; head word is always presented on data_out.
// PARAMETERS
//  WIDTH     16  data word width in bits (1..256)
//  DEPTH     5   number of storage words (2..256)
//  AE_LEVEL  1   almost_empty asserted when count <= AE_LEVEL (1..DEPTH-1)
//  AF_LEVEL  1   almost_full asserted when count >= DEPTH-AF_LEVEL (1..DEPTH-1)
//  ERR_MODE  0   0: error sticky until reset/diag; 1: error reflects current cycle only
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  rst           in   1      reset: synchronous, active-high
//  push_req_n    in   1      active-low push request
//  pop_req_n     in   1      active-low pop request
//  diag_n        in   1      active-low diagnostic clear: pointers/count/error to 0, memory kept
//  data_in       in   WIDTH  word to write on push
//  empty         out  1      count == 0
//  almost_empty  out  1      count <= AE_LEVEL
//  half_full     out  1      count >= (DEPTH+1)/2
//  almost_full   out  1      count >= DEPTH-AF_LEVEL
//  full          out  1      count == DEPTH
//  error         out  1      overflow/underflow indication
//  data_out      out  WIDTH  word at read pointer (head); combinational read of storage
// BEHAVIOUR
//  - State: mem[DEPTH], wr_ptr, rd_ptr (each 0..DEPTH-1), count (0..DEPTH), error reg.
//  - Pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of 2).
//  - rst=1 at clk edge: pointers=0, count=0, error=0, all mem words=0.
//    rst has priority over diag_n, push and pop.
//  - Outputs after reset: empty=1, almost_empty=1, half_full=0, almost_full=0,
//    full=0, error=0, data_out=0.
//  - diag_n=0 (rst=0): pointers=0, count=0, error=0; mem unchanged; push/pop ignored.
//  - Push only, not full: mem[wr_ptr]<=data_in, wr_ptr++, count++.
//  - Pop only, not empty: rd_ptr++, count--; data_out shows the next word after the edge.
//  - Push only when full: overflow; no write, no state change; error<=1.
//  - Pop only when empty: underflow; no state change; error<=1.
//  - Push+pop, 0<count<DEPTH: both performed; count unchanged.
//  - Push+pop when full: pop and write both performed; count stays DEPTH; no error.
//  - Push+pop when empty: push performed (count=1), pop is underflow; error<=1.
//  - Latency: a pushed word appears on data_out the cycle after the push edge if the FIFO was empty.
//  - Flags are combinational from the count register only (glitch-free, no input paths).
//  - ERR_MODE=0: error held until rst/diag_n.
//    ERR_MODE=1: error=1 only for the cycle after an offending request.
//  - data_out = mem[rd_ptr] at all times, including when empty (stale or 0).
// TESTING
//  - Reset: rst=1 for 1 cycle -> empty=1, almost_empty=1, full=0, error=0, data_out=0.
//  - Fill: push 0x0001..0x0005 on 5 cycles ->
//    after 1: empty=0, almost_empty=1, data_out=0x0001;
//    after 3: half_full=1; after 4: almost_full=1; after 5: full=1.
//  - Drain: 5 pops -> data_out sequence 0x0001..0x0005; empty=1 after 5th; error=0.
//  - Overflow: full, push 0x00AA -> contents unchanged, error=1 (held, ERR_MODE=0).
//  - Underflow: empty, pop -> error=1, count stays 0.
//    Push+pop when empty -> count=1, error=1.
//  - Wrap/simultaneous: keep count=3 with push+pop for 12 cycles ->
//    in-order data across pointer wrap, flags constant.
//    Then rst mid-stream -> all flags return to reset values.

Source files
------------

// File: rtl/fifo_s1_sf_if.sv
// Handshake and status bundle for the single-clock static-flag FIFO.
// The producer/credit side drives the master modport; the FIFO takes the slave modport.
interface fifo_s1_sf_if #(
  parameter int WIDTH = 16
) ();
  logic             push_req_n;
  logic             pop_req_n;
  logic             diag_n;
  logic [WIDTH-1:0] data_in;
  logic             empty;
  logic             almost_empty;
  logic             half_full;
  logic             almost_full;
  logic             full;
  logic             error;
  logic [WIDTH-1:0] data_out;

  modport master (
    output push_req_n, pop_req_n, diag_n, data_in,
    input  empty, almost_empty, half_full, almost_full, full, error, data_out
  );

  modport slave (
    input  push_req_n, pop_req_n, diag_n, data_in,
    output empty, almost_empty, half_full, almost_full, full, error, data_out
  );
endinterface

// File: rtl/fifo_s1_sf.sv
// Single-clock synchronous FIFO with count-derived status flags.
// Serves as the per-port NoC router output buffer; push/pop requests are active-low.
module fifo_s1_sf #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 5,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = 1,
  parameter int ERR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  fifo_s1_sf_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_MAX_C  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C       = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_C       = CW'(DEPTH - AF_LEVEL);
  localparam logic [CW-1:0] HF_C       = CW'((DEPTH + 1) / 2);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             error_r;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             err_s;
  logic [CW-1:0]    count_nxt_s;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PTR_MAX_C) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == DEPTH_C);
  assign push_s  = ~bus.push_req_n;
  assign pop_s   = ~bus.pop_req_n;

  // Decide which requests are honoured and whether this cycle over/underflows.
  always_comb begin
    do_pop_s    = 1'b0;
    do_push_s   = 1'b0;
    err_s       = 1'b0;
    count_nxt_s = count_r;
    do_pop_s    = pop_s & ~empty_s;
    // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
    do_push_s   = push_s & (~full_s | pop_s);
    err_s       = (push_s & ~pop_s & full_s) | (pop_s & empty_s);
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage, pointers, occupancy count and error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      error_r  <= 1'b0;
    end else if (!bus.diag_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      error_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= bus.data_in;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      if (ERR_MODE == 0) begin
        error_r <= error_r | err_s;
      end else begin
        error_r <= err_s;
      end
    end
  end

  // Flags decode the count register only, so they carry no input-to-output paths.
  assign bus.empty        = empty_s;
  assign bus.almost_empty = (count_r <= AE_C);
  assign bus.half_full    = (count_r >= HF_C);
  assign bus.almost_full  = (count_r >= AF_C);
  assign bus.full         = full_s;
  assign bus.error        = error_r;
  assign bus.data_out     = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_fifo_s1_sf.sv
// Directed bench for fifo_s1_sf: a stimulus process queues expected head words,
// a negedge monitor pops and compares them whenever a pop is accepted.
module tb_fifo_s1_sf;
  localparam int WIDTH = 16;
  localparam int DEPTH = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_s1_sf_if #(.WIDTH(WIDTH)) bus ();

  fifo_s1_sf #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AE_LEVEL(1), .AF_LEVEL(1), .ERR_MODE(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               mcount = 0;
  logic             exp_pop = 1'b0;

  // {empty, almost_empty, half_full, almost_full, full, error}
  task automatic chk(input string name, input logic [5:0] exp_f, input logic [WIDTH-1:0] exp_d);
    logic [5:0] act_f;
    act_f = {bus.empty, bus.almost_empty, bus.half_full, bus.almost_full, bus.full, bus.error};
    checks++;
    if (act_f !== exp_f) begin
      errors++;
      $display("FAIL %s flags actual=%b required=%b", name, act_f, exp_f);
    end
    checks++;
    if (bus.data_out !== exp_d) begin
      errors++;
      $display("FAIL %s data_out actual=%h required=%h", name, bus.data_out, exp_d);
    end
  endtask

  task automatic cycle(input logic push, input logic pop, input logic [WIDTH-1:0] d);
    logic push_ok;
    bus.push_req_n = ~push;
    bus.pop_req_n  = ~pop;
    bus.data_in    = d;
    exp_pop = pop && (mcount > 0);
    push_ok = push && ((mcount < DEPTH) || exp_pop);
    if (push_ok) exp_q.push_back(d);
    mcount = mcount + (push_ok ? 1 : 0) - (exp_pop ? 1 : 0);
    @(posedge clk);
    #1;
    bus.push_req_n = 1'b1;
    bus.pop_req_n  = 1'b1;
    exp_pop = 1'b0;
  endtask

  task automatic do_reset(input logic push);
    rst = 1'b1;
    bus.push_req_n = ~push;
    bus.data_in = 16'h00EE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.push_req_n = 1'b1;
    exp_q.delete();
    mcount = 0;
  endtask

  task automatic do_diag();
    bus.diag_n = 1'b0;
    @(posedge clk);
    #1;
    bus.diag_n = 1'b1;
    exp_q.delete();
    mcount = 0;
  endtask

  // Scoreboard monitor: the head word is checked just before each accepted pop edge.
  always @(negedge clk) begin
    if (exp_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data no expected word, actual=%h", bus.data_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL pop_data actual=%h required=%h", bus.data_out, e);
        end
      end
    end
  end

  initial begin
    bus.push_req_n = 1'b1;
    bus.pop_req_n  = 1'b1;
    bus.diag_n     = 1'b1;
    bus.data_in    = 16'h0000;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    do_reset(1'b0);
    chk("reset", 6'b110000, 16'h0000);

    cycle(1'b1, 1'b0, 16'h0001); chk("fill1", 6'b010000, 16'h0001);
    cycle(1'b1, 1'b0, 16'h0002); chk("fill2", 6'b000000, 16'h0001);
    cycle(1'b1, 1'b0, 16'h0003); chk("fill3", 6'b001000, 16'h0001);
    cycle(1'b1, 1'b0, 16'h0004); chk("fill4", 6'b001100, 16'h0001);
    cycle(1'b1, 1'b0, 16'h0005); chk("fill5", 6'b001110, 16'h0001);

    cycle(1'b0, 1'b1, 16'h0000); chk("drain1", 6'b001100, 16'h0002);
    cycle(1'b0, 1'b1, 16'h0000); chk("drain2", 6'b001000, 16'h0003);
    cycle(1'b0, 1'b1, 16'h0000); chk("drain3", 6'b000000, 16'h0004);
    cycle(1'b0, 1'b1, 16'h0000); chk("drain4", 6'b010000, 16'h0005);
    cycle(1'b0, 1'b1, 16'h0000); chk("drain5", 6'b110000, 16'h0001);

    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 16'h0010 + 16'(i));
    chk("refill", 6'b001110, 16'h0011);
    cycle(1'b1, 1'b0, 16'h00AA); chk("overflow", 6'b001111, 16'h0011);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 16'h0000);
    chk("drain_after_ovf", 6'b110001, 16'h0011);

    cycle(1'b1, 1'b0, 16'h0021); chk("err_held1", 6'b010001, 16'h0021);
    cycle(1'b1, 1'b0, 16'h0022); chk("err_held2", 6'b000001, 16'h0021);
    cycle(1'b0, 1'b1, 16'h0000); chk("pre_diag", 6'b010001, 16'h0022);
    do_diag();                   chk("diag", 6'b110000, 16'h0021);

    cycle(1'b0, 1'b1, 16'h0000); chk("underflow", 6'b110001, 16'h0021);
    cycle(1'b1, 1'b1, 16'h0031); chk("pushpop_empty", 6'b010001, 16'h0031);
    do_reset(1'b0);              chk("reset2", 6'b110000, 16'h0000);

    cycle(1'b1, 1'b0, 16'h0041);
    cycle(1'b1, 1'b0, 16'h0042);
    cycle(1'b1, 1'b0, 16'h0043); chk("wrap_prefill", 6'b001000, 16'h0041);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, 1'b1, 16'h0043 + 16'(k));
      chk($sformatf("wrap%0d", k), 6'b001000, 16'h0041 + 16'(k));
    end

    cycle(1'b1, 1'b0, 16'h0050); chk("refill_af", 6'b001100, 16'h004D);
    cycle(1'b1, 1'b0, 16'h0051); chk("refill_full", 6'b001110, 16'h004D);
    cycle(1'b1, 1'b1, 16'h0052); chk("pushpop_full", 6'b001110, 16'h004E);

    do_reset(1'b1);              chk("reset_midstream", 6'b110000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
